adder_node_depacketizer: RTL and testbench
==========================================

ADDER_NODE_DEPACKETIZER -- requirements
Module: adder_node_depacketizer

Interface
REQ-001 Parameter DWIDTH, default 8, psum data width.
REQ-002 Parameter PWIDTH, default 47, NoC packet width.
REQ-003 Parameter QDEPTH, default 4, per-source psum queue depth (power of two, >=2).
REQ-004 Parameter ADDER_ADDR, default 3'd4, this node's NoC address.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 in_valid  input  1  packet from router valid.
REQ-009 in_ready  output  1  node accepts packet this cycle.
REQ-010 in_packet  input  PWIDTH  {type[46], dest[45:43], src[42:40], data[39:0]}; psum in data[DWIDTH-1:0].
REQ-011 out_valid  output  1  summed psum available.
REQ-012 out_ready  input  1  downstream accepts sum.
REQ-013 out_sum  output  DWIDTH+2  sum of one psum from each of the three PEs.
REQ-014 out_seq  output  8  group index of out_sum, wraps 255->0.
REQ-015 err_drop  output  1  one-cycle pulse per dropped packet.
REQ-016 drop_count  output  8  saturating count of dropped packets.

Function
REQ-017 Input handshake occurs when in_valid && in_ready on a rising edge; out handshake when out_valid && out_ready.
REQ-018 Valid psum packet: type==1, dest==ADDER_ADDR, src in {3'd3, 3'd1, 3'd0}; mapped to queue index 0, 1, 2 respectively.
REQ-019 Valid psum packet written into its source queue on handshake; upper data bits [39:DWIDTH] ignored.
REQ-020 Any other packet (type==0 filter frame, wrong dest, unknown src) accepted (in_ready=1 regardless of queues), discarded, err_drop pulses cycle after handshake, drop_count increments, holding at 255.
REQ-021 in_ready = 0 only when in_valid carries a valid psum packet whose target queue is full; a pop of that queue in the same cycle does not raise in_ready.
REQ-022 Group fires when all three queues non-empty and output register empty or being handshaked that cycle: pop one entry from each queue, load out_sum = zero-extended sum of the three, out_valid=1 next cycle.
REQ-023 Arithmetic unsigned; DWIDTH+2 bits; no overflow possible.
REQ-024 Latency: handshake of the last contributing psum at edge N -> out_valid high after edge N+2.
REQ-025 out_sum/out_seq stable while out_valid && !out_ready; back-to-back groups sustain one sum per cycle.
REQ-026 out_seq increments by one per fired group; first group after reset has out_seq 0.
REQ-027 Per-source ordering preserved: k-th psum from each source combined in group k, independent of arrival interleaving.
REQ-028 Queue write and pop on same queue same cycle allowed; occupancy unchanged.
REQ-029 Reset mid-operation discards all queued psums and any pending output.

Reset
REQ-030 On rst_n low: out_valid=0, out_sum=0, out_seq=0, err_drop=0, drop_count=0, all queues empty, in_ready reflects empty queues (1).
REQ-031 Reset release synchronous-safe: no handshake counted on the edge where rst_n deasserts.

Structure
REQ-032 Shared package holds packet field offsets, type encodings (IFM/psum=1, filter=0), PE addresses 3/1/0, adder address 4.
REQ-033 One sub-module: psum_fifo (synchronous FIFO, DWIDTH wide, QDEPTH deep, full/empty flags), instantiated three times.
REQ-034 Decode, group-fire logic, output register and drop counter in top level.

Verification
REQ-035 Psums 10,20,30 from src 3,1,0 in one burst -> out_sum=60, out_seq=0, two cycles after last handshake.
REQ-036 Src 3 sends 5 psums (1..5) before others send any -> 5th stalls (in_ready=0) with QDEPTH=4; after src 1 and 0 each send 0 -> out_sum=1, stalled packet then accepted.
REQ-037 Filter packet (type 0, dest 0, src 3) and psum with dest 2 -> both accepted, err_drop two pulses, drop_count=2, no out_valid.
REQ-038 All psums 255 -> out_sum=765 (10'h2FD).
REQ-039 out_ready held low 10 cycles with three full groups queued -> out_sum held, then three consecutive sums with out_seq 0,1,2.
REQ-040 rst_n asserted with 2 entries queued and out_valid high -> all outputs to reset values immediately; subsequent group gives out_seq 0.

Source files
------------

// File: rtl/adder_node_depacketizer_pkg.sv
// Shared packet layout, type encodings and NoC addresses for the adder node.
package adder_node_depacketizer_pkg;

    localparam int TYPE_POS = 46;
    localparam int DEST_HI  = 45;
    localparam int DEST_LO  = 43;
    localparam int SRC_HI   = 42;
    localparam int SRC_LO   = 40;
    localparam int DATA_HI  = 39;

    localparam logic TYPE_PSUM   = 1'b1;
    localparam logic TYPE_FILTER = 1'b0;

    localparam logic [2:0] PE0_ADDR           = 3'd3;
    localparam logic [2:0] PE1_ADDR           = 3'd1;
    localparam logic [2:0] PE2_ADDR           = 3'd0;
    localparam logic [2:0] ADDER_ADDR_DEFAULT = 3'd4;

    localparam int NUM_SRC = 3;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } src_map_t;

    // Map a PE source address onto its psum queue index.
    function automatic src_map_t map_src(input logic [2:0] src);
        src_map_t m;
        m.hit = 1'b1;
        m.idx = 2'd0;
        case (src)
            PE0_ADDR: m.idx = 2'd0;
            PE1_ADDR: m.idx = 2'd1;
            PE2_ADDR: m.idx = 2'd2;
            default: begin
                m.hit = 1'b0;
                m.idx = 2'd0;
            end
        endcase
        return m;
    endfunction

endpackage

// File: rtl/adder_node_depacketizer_psum_fifo.sv
// Synchronous first-word-fall-through FIFO holding psums from one PE.
module psum_fifo #(
    parameter int  DWIDTH = 8,
    parameter int  QDEPTH = 4,
    localparam int PW     = $clog2(QDEPTH),
    localparam int CW     = PW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [DWIDTH-1:0] mem_r [QDEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              do_wr_s;
    logic              do_rd_s;

    assign full    = (count_r == CW'(QDEPTH));
    assign empty   = (count_r == CW'(0));
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];
    assign do_rd_s = rd_en && !empty;
    assign do_wr_s = wr_en && (!full || do_rd_s);

    // Storage array; contents are don't-care while the pointers say empty.
    always_ff @(posedge clk) begin
        if (do_wr_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_wr_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (do_rd_s) rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({do_wr_s, do_rd_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/adder_node_depacketizer.sv
// Adder node: sorts psum packets into per-PE queues, sums one psum from each
// PE per group and counts packets that are not psums addressed to this node.
module adder_node_depacketizer
    import adder_node_depacketizer_pkg::*;
#(
    parameter int         DWIDTH     = 8,
    parameter int         PWIDTH     = 47,
    parameter int         QDEPTH     = 4,
    parameter logic [2:0] ADDER_ADDR = ADDER_ADDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PWIDTH-1:0] in_packet,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH+1:0] out_sum,
    output logic [7:0]        out_seq,
    output logic              err_drop,
    output logic [7:0]        drop_count
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int SW = DWIDTH + 2;

    src_map_t          map_s;
    logic              is_psum_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              fire_s;
    logic [SW-1:0]     sum_s;
    logic              unused_data_s;

    logic              pipe_valid_r;
    logic [1:0]        pipe_idx_r;
    logic [DWIDTH-1:0] pipe_data_r;

    logic [NUM_SRC-1:0] wr_en_s;
    logic [NUM_SRC-1:0] full_s;
    logic [NUM_SRC-1:0] empty_s;
    logic [NUM_SRC-1:0] blocked_s;
    logic [DWIDTH-1:0]  rd_data_s [NUM_SRC];
    logic [CW-1:0]      count_s   [NUM_SRC];

    logic              out_valid_r;
    logic [SW-1:0]     out_sum_r;
    logic [7:0]        out_seq_r;
    logic [7:0]        grp_cnt_r;
    logic              err_drop_r;
    logic [7:0]        drop_count_r;

    assign map_s         = map_src(in_packet[SRC_HI:SRC_LO]);
    assign is_psum_s     = (in_packet[TYPE_POS] == TYPE_PSUM) &&
                           (in_packet[DEST_HI:DEST_LO] == ADDER_ADDR) && map_s.hit;
    assign unused_data_s = ^in_packet[DATA_HI:DWIDTH];

    // A queue counts as full when the staged psum still in flight will fill it.
    for (genvar q = 0; q < NUM_SRC; q++) begin : g_queue
        assign wr_en_s[q]   = pipe_valid_r && (pipe_idx_r == 2'(q));
        assign blocked_s[q] = full_s[q] || (wr_en_s[q] && (count_s[q] == CW'(QDEPTH - 1)));

        psum_fifo #(
            .DWIDTH (DWIDTH),
            .QDEPTH (QDEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en_s[q]),
            .wr_data (pipe_data_r),
            .rd_en   (fire_s),
            .rd_data (rd_data_s[q]),
            .full    (full_s[q]),
            .empty   (empty_s[q]),
            .count   (count_s[q])
        );
    end

    // Backpressure only for a psum whose queue has no room; pops are ignored.
    always_comb begin
        in_ready_s = 1'b1;
        if (in_valid && is_psum_s && blocked_s[map_s.idx]) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = 1'b1;
        end
    end

    assign in_ready = in_ready_s;
    assign accept_s = in_valid && in_ready_s;
    assign fire_s   = (&(~empty_s)) && (!out_valid_r || out_ready);
    assign sum_s    = SW'(rd_data_s[0]) + SW'(rd_data_s[1]) + SW'(rd_data_s[2]);

    // Input staging register and drop accounting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid_r <= 1'b0;
            pipe_idx_r   <= 2'd0;
            pipe_data_r  <= '0;
            err_drop_r   <= 1'b0;
            drop_count_r <= 8'd0;
        end else begin
            pipe_valid_r <= accept_s && is_psum_s;
            pipe_idx_r   <= map_s.idx;
            pipe_data_r  <= in_packet[DWIDTH-1:0];
            err_drop_r   <= accept_s && !is_psum_s;
            if (accept_s && !is_psum_s && (drop_count_r != 8'hFF)) begin
                drop_count_r <= drop_count_r + 8'd1;
            end
        end
    end

    // Output register: loads a new group sum whenever a group fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_sum_r   <= '0;
            out_seq_r   <= 8'd0;
            grp_cnt_r   <= 8'd0;
        end else if (fire_s) begin
            out_valid_r <= 1'b1;
            out_sum_r   <= sum_s;
            out_seq_r   <= grp_cnt_r;
            grp_cnt_r   <= grp_cnt_r + 8'd1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_sum    = out_sum_r;
    assign out_seq    = out_seq_r;
    assign err_drop   = err_drop_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_adder_node_depacketizer.sv
// Randomised bench for adder_node_depacketizer with a queue-based reference model.
module tb_adder_node_depacketizer;

    localparam int PW = 47;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic [PW-1:0] in_packet = '0;
    logic          in_ready;
    logic          out_valid;
    logic [9:0]    out_sum;
    logic [7:0]    out_seq;
    logic          err_drop;
    logic [7:0]    drop_count;

    adder_node_depacketizer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_packet  (in_packet),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sum    (out_sum),
        .out_seq    (out_seq),
        .err_drop   (err_drop),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: unmatched psums per source, expected output stream.
    int unsigned mq [3][$];
    int unsigned exp_sum_q [$];
    int unsigned exp_seq_q [$];
    int unsigned seq_m      = 0;
    int          drops_m    = 0;
    int          seen_drops = 0;
    int          ready_mode = 1;

    function automatic logic [46:0] mk(input bit t, input logic [2:0] d, input logic [2:0] s);
        logic [39:0] data;
        data = {8'($urandom), 32'($urandom)};
        return {t, d, s, data};
    endfunction

    function automatic logic [46:0] psum(input logic [2:0] s, input logic [7:0] v);
        logic [31:0] hi;
        hi = $urandom;
        return {1'b1, 3'd4, s, hi, v};
    endfunction

    task automatic model_accept(input logic [46:0] p);
        int idx;
        case (p[42:40])
            3'd3:    idx = 0;
            3'd1:    idx = 1;
            3'd0:    idx = 2;
            default: idx = -1;
        endcase
        if (p[46] == 1'b1 && p[45:43] == 3'd4 && idx >= 0) begin
            mq[idx].push_back(int'(p[7:0]));
            if (mq[0].size() > 0 && mq[1].size() > 0 && mq[2].size() > 0) begin
                exp_sum_q.push_back(mq[0].pop_front() + mq[1].pop_front() + mq[2].pop_front());
                exp_seq_q.push_back(seq_m % 256);
                seq_m++;
            end
        end else begin
            drops_m++;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mq[i].delete();
        exp_sum_q.delete();
        exp_seq_q.delete();
        seq_m      = 0;
        drops_m    = 0;
        seen_drops = 0;
    endtask

    // Offer one packet from a negedge; returns at the negedge after its handshake.
    task automatic send(input logic [46:0] p);
        int w;
        w         = 0;
        in_valid  = 1'b1;
        in_packet = p;
        #1;
        while (in_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (in_ready === 1'b1) begin
            @(posedge clk);
            model_accept(p);
            @(negedge clk);
        end else begin
            chk_eq("send_timeout", in_ready, 1'b1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int w;
        w = 0;
        while (out_valid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk_eq(tag, out_valid, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_eq("rst_out_valid", out_valid, 1'b0);
        chk_eq("rst_out_sum", out_sum, 10'd0);
        chk_eq("rst_out_seq", out_seq, 8'd0);
        chk_eq("rst_err_drop", err_drop, 1'b0);
        chk_eq("rst_drop_count", drop_count, 8'd0);
        chk_eq("rst_in_ready", in_ready, 1'b1);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        #3;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(3) != 0);
        endcase
    end

    logic       hold_v   = 1'b0;
    logic [9:0] hold_sum = '0;
    logic [7:0] hold_seq = '0;

    // Output scoreboard: every handshake against the model, stability under stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (err_drop === 1'b1) seen_drops++;
            if (out_valid === 1'b1) begin
                if (hold_v) begin
                    chk_eq("hold_sum", out_sum, hold_sum);
                    chk_eq("hold_seq", out_seq, hold_seq);
                end
                if (out_ready) begin
                    if (exp_sum_q.size() == 0) begin
                        chk_eq("out_unexpected", out_valid, 1'b0);
                    end else begin
                        chk_eq("out_sum", out_sum, exp_sum_q.pop_front());
                        chk_eq("out_seq", out_seq, exp_seq_q.pop_front());
                    end
                    hold_v = 1'b0;
                end else begin
                    hold_v   = 1'b1;
                    hold_sum = out_sum;
                    hold_seq = out_seq;
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          idx;
        int          r;
        logic [2:0]  s;
        logic [2:0]  codes [3];
        logic [7:0]  vals [9];
        codes[0] = 3'd3;
        codes[1] = 3'd1;
        codes[2] = 3'd0;

        do_reset();

        // Single burst and latency.
        send(psum(3'd3, 8'd10));
        send(psum(3'd1, 8'd20));
        send(psum(3'd0, 8'd30));
        chk_eq("lat_n0", out_valid, 1'b0);
        @(negedge clk);
        chk_eq("lat_n1", out_valid, 1'b0);
        @(negedge clk);
        chk_eq("lat_n2", out_valid, 1'b1);
        chk_eq("burst_sum", out_sum, 10'd60);
        chk_eq("burst_seq", out_seq, 8'd0);

        // Queue-full stall on source 3.
        for (int i = 1; i <= 4; i++) send(psum(3'd3, 8'(i)));
        in_valid  = 1'b1;
        in_packet = psum(3'd3, 8'd5);
        #1 chk_eq("stall0", in_ready, 1'b0);
        @(negedge clk);
        #1 chk_eq("stall1", in_ready, 1'b0);
        in_valid = 1'b0;
        send(psum(3'd1, 8'd0));
        send(psum(3'd0, 8'd0));
        wait_out("wait_stall_grp");
        chk_eq("stall_grp_sum", out_sum, 10'd1);
        send(psum(3'd3, 8'd5));

        // Dropped packets.
        do_reset();
        send(mk(1'b0, 3'd0, 3'd3));
        chk_eq("drop_pulse0", err_drop, 1'b1);
        send(mk(1'b1, 3'd2, 3'd0));
        chk_eq("drop_pulse1", err_drop, 1'b1);
        @(negedge clk);
        chk_eq("drop_count2", drop_count, 8'd2);
        chk_eq("drop_pulses2", seen_drops, 32'd2);
        for (int i = 0; i < 5; i++) begin
            chk_eq("drop_no_out", out_valid, 1'b0);
            @(negedge clk);
        end

        // Maximum operands.
        for (int i = 0; i < 3; i++) send(psum(codes[i], 8'd255));
        wait_out("wait_max");
        chk_eq("max_sum", out_sum, 10'h2FD);

        // Held output with three groups queued, then back-to-back drain.
        do_reset();
        ready_mode = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) vals[i] = 8'($urandom);
        for (int g = 0; g < 3; g++) begin
            send(psum(3'd0, vals[3*g+2]));
            send(psum(3'd3, vals[3*g]));
            send(psum(3'd1, vals[3*g+1]));
        end
        wait_out("wait_hold");
        repeat (10) @(negedge clk);
        chk_eq("held_valid", out_valid, 1'b1);
        chk_eq("held_sum", out_sum, exp_sum_q[0]);
        chk_eq("held_seq", out_seq, 8'd0);
        ready_mode = 1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk_eq("b2b_valid", out_valid, 1'b1);
            chk_eq("b2b_seq", out_seq, 32'(k));
            @(negedge clk);
        end

        // Reset with a pending output and two queued psums.
        ready_mode = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) send(psum(codes[i], 8'($urandom)));
        send(psum(3'd3, 8'd7));
        send(psum(3'd1, 8'd9));
        wait_out("wait_pre_rst");
        do_reset();
        ready_mode = 1;
        send(psum(3'd1, 8'd3));
        send(psum(3'd3, 8'd4));
        send(psum(3'd0, 8'd5));
        wait_out("wait_post_rst");
        chk_eq("post_rst_seq", out_seq, 8'd0);
        chk_eq("post_rst_sum", out_sum, 10'd12);

        // Randomised traffic with random output backpressure.
        ready_mode = 2;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(99);
            if (r < 75) begin
                idx = $urandom_range(2);
                if (mq[idx].size() >= 3) begin
                    idx = 0;
                    for (int j = 1; j < 3; j++) if (mq[j].size() < mq[idx].size()) idx = j;
                end
                send(psum(codes[idx], 8'($urandom)));
            end else if (r < 83) begin
                send(mk(1'b0, 3'd4, codes[$urandom_range(2)]));
            end else if (r < 91) begin
                s = 3'($urandom_range(3)) + ((3'($urandom_range(3)) >= 3'd0) ? 3'd5 : 3'd5);
                send(mk(1'b1, s, codes[$urandom_range(2)]));
            end else begin
                s = ($urandom_range(1) == 0) ? 3'd2 : 3'(4 + $urandom_range(3));
                send(mk(1'b1, 3'd4, s));
            end
            if ($urandom_range(3) == 0) @(negedge clk);
        end
        ready_mode = 1;
        w = 0;
        while (exp_sum_q.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        chk_eq("drain_valid", out_valid, 1'b0);
        chk_eq("rand_drop_count", drop_count, (drops_m > 255) ? 32'd255 : 32'(drops_m));
        chk_eq("rand_drop_pulses", seen_drops, 32'(drops_m));

        // Saturation of the drop counter.
        for (int i = 0; i < 260; i++) send(mk(1'b0, 3'd0, 3'd3));
        @(negedge clk);
        chk_eq("drop_sat", drop_count, 8'd255);
        chk_eq("drop_sat_pulses", seen_drops, 32'(drops_m));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
